// File: rtl/rot_pkg.sv
// Shared constants for the rotator arbiter: data/count widths, opcodes and requester ids.
// Opcodes 5..7 are reserved and return the operand unchanged with an error flag.
package rot_pkg;

   localparam int W  = 16;
   localparam int CW = 4;

   localparam logic [2:0] OP_ROL = 3'd0;
   localparam logic [2:0] OP_ROR = 3'd1;
   localparam logic [2:0] OP_SLL = 3'd2;
   localparam logic [2:0] OP_SRL = 3'd3;
   localparam logic [2:0] OP_SRA = 3'd4;

   localparam logic ID_ALU = 1'b0;
   localparam logic ID_BMU = 1'b1;

endpackage

// File: rtl/left_rotate.sv
// Combinational barrel rotator: Out = In rotated left by Cnt positions.
// Each output bit selects In[(i - Cnt) mod W]. The index wraps naturally because it is truncated to CW bits.
module left_rotate #(
   parameter int W  = 16,
   parameter int CW = 4
) (
   input  logic [W-1:0]  In,
   input  logic [CW-1:0] Cnt,
   output logic [W-1:0]  Out
);

   always_comb begin
      Out = '0;
      for (int i = 0; i < W; i++) begin
         Out[i] = In[CW'(i - int'(Cnt))];
      end
   end

endmodule

// File: rtl/rotate_arbiter.sv
// Round-robin arbiter sharing one left rotator between the ALU (id 0) and the bit-manipulation
// helper (id 1). It derives ROL/ROR/SLL/SRL/SRA from the rotator output and returns a registered, id-tagged result.
module rotate_arbiter #(
   parameter int W  = 16,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [2:0]    req0_op,
   input  logic [W-1:0]  req0_data,
   input  logic [CW-1:0] req0_cnt,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [2:0]    req1_op,
   input  logic [W-1:0]  req1_data,
   input  logic [CW-1:0] req1_cnt,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [W-1:0]  res_data,
   output logic          res_id,
   output logic          res_err
);

   import rot_pkg::*;

   // Handshake: a transfer happens on a clk edge where valid && ready are both high. Ready may depend
   // combinationally on res_ready. An ungranted requester keeps valid and payload stable until it is accepted.
   logic          res_valid_q, res_valid_d;
   logic [W-1:0]  res_data_q,  res_data_d;
   logic          res_id_q,    res_id_d;
   logic          res_err_q,   res_err_d;
   logic          last_grant_q, last_grant_d;

   logic          can_accept;
   logic          grant;
   logic          xfer;
   logic [2:0]    sel_op;
   logic [W-1:0]  sel_data;
   logic [CW-1:0] sel_cnt;
   logic [CW-1:0] rot_amt;
   logic [W-1:0]  rot_out;
   logic [W-1:0]  shl_mask;
   logic [W-1:0]  shr_mask;
   logic [W-1:0]  op_result;
   logic          op_err;

   always_comb begin
      can_accept = !res_valid_q || res_ready;
      if (req0_valid && req1_valid) begin
         grant = ~last_grant_q;
      end else begin
         grant = req1_valid;
      end
      req0_ready = rst_n && can_accept && (grant == ID_ALU);
      req1_ready = rst_n && can_accept && (grant == ID_BMU);
      xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
   end

   always_comb begin
      sel_op   = (grant == ID_BMU) ? req1_op   : req0_op;
      sel_data = (grant == ID_BMU) ? req1_data : req0_data;
      sel_cnt  = (grant == ID_BMU) ? req1_cnt  : req0_cnt;
      // Right-going ops rotate left by (W - cnt) mod W, so cnt=0 becomes a zero rotate.
      if (sel_op == OP_ROR || sel_op == OP_SRL || sel_op == OP_SRA) begin
         rot_amt = CW'(W - int'(sel_cnt));
      end else begin
         rot_amt = sel_cnt;
      end
   end

   left_rotate #(.W(W), .CW(CW)) u_left_rotate (
      .In  (sel_data),
      .Cnt (rot_amt),
      .Out (rot_out)
   );

   always_comb begin
      shl_mask  = {W{1'b1}} << sel_cnt;
      shr_mask  = {W{1'b1}} >> sel_cnt;
      op_result = sel_data;
      op_err    = 1'b0;
      case (sel_op)
         OP_ROL, OP_ROR: op_result = rot_out;
         OP_SLL:         op_result = rot_out & shl_mask;
         OP_SRL:         op_result = rot_out & shr_mask;
         OP_SRA:         op_result = (rot_out & shr_mask) | (sel_data[W-1] ? ~shr_mask : '0);
         default: begin
            op_result = sel_data;
            op_err    = 1'b1;
         end
      endcase
   end

   always_comb begin
      res_valid_d  = res_valid_q;
      res_data_d   = res_data_q;
      res_id_d     = res_id_q;
      res_err_d    = res_err_q;
      last_grant_d = last_grant_q;
      if (xfer) begin
         res_valid_d  = 1'b1;
         res_data_d   = op_result;
         res_id_d     = grant;
         res_err_d    = op_err;
         last_grant_d = grant;
      end else if (res_ready) begin
         res_valid_d  = 1'b0;
      end
   end

   // last_grant resets to 1 so requester 0 wins the first contention.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_valid_q  <= 1'b0;
         res_data_q   <= '0;
         res_id_q     <= 1'b0;
         res_err_q    <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         res_valid_q  <= res_valid_d;
         res_data_q   <= res_data_d;
         res_id_q     <= res_id_d;
         res_err_q    <= res_err_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;
   assign res_err   = res_err_q;

endmodule

// File: doc/rotate_arbiter.md
Name: rotate_arbiter

Overview:
Shares the single 16-bit barrel rotator between two requesters: port 0 is the CPU ALU and port 1 is the bit-manipulation/graphics helper. It arbitrates round-robin with valid/ready handshakes and derives ROL/ROR/SLL/SRL/SRA from one left-rotate plus masking. Results are returned through one registered result channel tagged with the requester id.

Parameters:
W, 16, data width (fixed at 16 to match the rotator; other values unsupported)
CW, 4, shift-count width (log2 W)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle (when valid)
req0_op  input  3  opcode, see Behaviour
req0_data  input  16  operand
req0_cnt  input  4  shift/rotate amount 0..15
req1_valid/req1_ready/req1_op/req1_data/req1_cnt  same as requester 0, for requester 1
res_valid  output  1  result register holds a result
res_ready  input  1  consumer takes result this cycle
res_data  output  16  result
res_id  output  1  requester that issued the result
res_err  output  1  opcode was reserved (5..7)

Behaviour:
- Reset (rst_n low at a clk edge): res_valid=0, res_data=0, res_id=0, res_err=0, last_grant=1. A result still held in the register at that edge is dropped, not delivered. reqN_ready is 0 while rst_n is low.
- Slot free: can_accept = !res_valid || res_ready. This depends combinationally on res_ready, so back-to-back throughput is 1 op/cycle.
- Arbitration:
  - If only one reqN_valid is high, grant that requester.
  - If both are high, grant the requester != last_grant. After reset, requester 0 wins the first contention.
  - last_grant updates only on an actual transfer (valid && ready).
- reqN_ready = can_accept && grant==N. It is never high for both requesters. The ungranted requester must hold its valid and payload stable until accepted.
- Latency: an op accepted at edge N appears with res_valid=1 after edge N and stays until the edge where res_valid && res_ready.
- If accept and drain happen in the same cycle, the new result replaces the old one and res_valid stays 1.
- If nothing is accepted and res_ready=1, res_valid goes to 0. res_data holds its last value.
- Opcodes (r = rotator output, left by amount a):
  - 0 ROL: a=cnt; result = r
  - 1 ROR: a=(16-cnt) mod 16; result = r
  - 2 SLL: a=cnt; result = r & (16'hFFFF << cnt)
  - 3 SRL: a=(16-cnt) mod 16; result = r & (16'hFFFF >> cnt)
  - 4 SRA: same as SRL, then OR with ~(16'hFFFF >> cnt) when data[15]=1
  - 5..7 reserved: result = data unchanged, res_err=1
- res_err=0 for opcodes 0..4. cnt=0 returns data unchanged for every opcode.
- All datapath arithmetic is 16-bit, and the amount a wraps mod 16. No state other than last_grant and the result register.

Decomposition:
- Shared package rot_pkg holds: W=16, CW=4, opcode constants OP_ROL=0, OP_ROR=1, OP_SLL=2, OP_SRL=3, OP_SRA=4, and the requester id constants ID_ALU=0, ID_BMU=1.
- One sub-module: instantiate the existing left_rotate (In, Cnt, Out) once, on the granted request's data and amount.
- Mask and sign-fill logic is local combinational logic inside rotate_arbiter.

Test Plan:
- Reset then single op: req0 ROL data=16'h8001 cnt=1 -> req0_ready=1 same cycle; next cycle res_valid=1, res_data=16'h0003, res_id=0, res_err=0.
- Op coverage on data=16'hF00F, cnt=4:
  - ROR -> 16'hFF00
  - SLL -> 16'h00F0
  - SRL -> 16'h0F00
  - SRA -> 16'hFF00
  - SRA on 16'h700F cnt=4 -> 16'h0700
  - cnt=0 on all five ops -> 16'hF00F
- Contention: both valid every cycle, res_ready=1 -> grants alternate 0,1,0,1; res_id sequence 0,1,0,1; no overlap of req0_ready and req1_ready.
- Backpressure: res_ready=0 with a result held -> both readies 0 and res_data stable for 5 cycles; when res_ready=1 with a new op pending -> swap in one cycle, res_valid stays 1.
- Reserved op: req1 op=6 data=16'h1234 -> res_data=16'h1234, res_err=1, res_id=1.
- Reset mid-operation: result held with res_ready=0, assert rst_n=0 for one edge -> res_valid=0, res_data=0; next contention grants requester 0 first.
